fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the multicycle MIPS32 core: owns the program counter and instruction register, and issues a request/acknowledge read to instruction memory when the stage counter pulses the IF strobe. It sits directly upstream of the stage counter. It supplies `op_code`/`funct` from the latched instruction, which the counter uses to choose the post-decode stage sequence. It raises `fetch_busy` so the counter holds while memory is slow.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `WAIT_MAX`, 8, cycles a request may wait for `imem_ack` before it is aborted.
- `WAIT_W`, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_clk`  in  1  one-cycle fetch strobe from the stage counter.
- `inst_read_en`  in  1  fetch permitted; a fetch starts only when `if_clk` and `inst_read_en` are both 1.
- `pc_load`  in  1  redirect strobe from EX (branch/jump).
- `pc_next`  in  32  redirect target.
- `imem_req`  out  1  memory read request, registered.
- `imem_addr`  out  32  read address, stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc`+4, combinational.
- `inst`  out  32  instruction register.
- `op_code`  out  `OP_WIDTH`  inst[31:26].
- `funct`  out  `FUNCT_WIDTH`  inst[5:0].
- `rs`, `rt`, `rd`  out  5 each  inst[25:21], [20:16], [15:11].
- `imm16`  out  16  inst[15:0].
- `addr26`  out  26  inst[25:0].
- `inst_valid`  out  1  `inst` holds a good fetch; cleared at each fetch start.
- `fetch_busy`  out  1  fetch in progress; counter must not advance.
- `fetch_fault`  out  1  one-cycle pulse on a misaligned PC or a timeout.

## Operation
- FSM states: IDLE, WAIT.
- **IDLE, start condition and PC aligned:**
  - Set `imem_req`=1 and `imem_addr`=`pc`.
  - Clear `inst_valid` and the wait counter.
  - Set `fetch_busy`=1 and go to WAIT.
- **IDLE, start condition and `pc`[1:0]≠0:**
  - No request is issued.
  - `inst`←0 (NOP), `inst_valid`←0, `fetch_fault` pulses.
  - Stay in IDLE.
- **WAIT, `imem_ack`=1:**
  - `inst`←`imem_rdata`, `inst_valid`←1.
  - `imem_req`←0, `fetch_busy`←0.
  - `pc`←`pc`+4 unless a redirect applies (see redirect rules).
  - Go to IDLE.
- **WAIT, no ack, wait counter = WAIT_MAX−1:**
  - Abort: `imem_req`←0, `inst`←0, `inst_valid`←0.
  - `fetch_fault` pulses, `pc` is unchanged.
  - Go to IDLE.
- **WAIT otherwise:** increment the wait counter; `imem_addr` is held.
- **Redirect (`pc_load`=1) in any state:** `pc`←`pc_next`.
  - In the same cycle as an ack, `pc_load` wins and the +4 is discarded.
  - During WAIT, a latched flag suppresses the +4 at ack; the in-flight instruction is still delivered.
- **Start strobe while in WAIT:** ignored.
- **Decoded fields:** combinational slices of `inst`; they change only when `inst` changes.
- **Arithmetic:** PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- **Reset values (`rst`=0, asynchronous):**
  - `pc`=`RESET_PC`, `inst`=0, all fields 0.
  - `inst_valid`, `imem_req`, `fetch_busy`, `fetch_fault` = 0; FSM in IDLE.
- **Latency:** start strobe sampled at edge T gives `imem_req`=1 after T. Ack sampled at edge T+k (k≥1) gives `inst_valid`=1 and new `pc` after T+k. Minimum is 2 edges from strobe to valid instruction.
- **Reset asserted mid-WAIT:** `imem_req` drops immediately (asynchronous); no partial capture.
- **Ack outside WAIT:** ignored.
- **`fetch_fault`:** high exactly one cycle per event.

## Structure
- `defines.v` owns `OP_WIDTH`, `FUNCT_WIDTH`, `TRUE`/`FALSE`, and the new `INST_NOP` (32'h0) and `RESET_PC` defaults.
- FSM state encodings stay local.
- No sub-module: a single module with the FSM, PC register, instruction register, wait counter and field slicing.

## Test plan
- **Reset and first fetch:** reset, then `if_clk`=`inst_read_en`=1 for one cycle, ack one cycle later with 32'h2008_0005 → `imem_addr`=0, `inst`=32'h2008_0005, `op_code`=6'h08, `rt`=8, `imm16`=5, `pc`=4, `inst_valid`=1.
- **Slow memory:** ack delayed 5 cycles → `fetch_busy`=1 for 5 cycles, `imem_addr` stable, one capture only.
- **Timeout:** no ack, WAIT_MAX=8 → `imem_req` drops after 8 cycles, `fetch_fault` pulse, `inst`=0, `pc` unchanged.
- **Redirect colliding with ack:** `pc_load`=1 with `pc_next`=32'h40 in the same cycle as ack → `pc`=32'h40, not `pc`+4; instruction is still captured.
- **Misaligned PC:** redirect to 32'h42, then strobe → no `imem_req`, `fetch_fault` pulse, `inst`=0.
- **Wrap and ignored strobe:** PC at 32'hFFFF_FFFC, then fetch → `pc`=0. A strobe during WAIT is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage of the multicycle MIPS32 core.
package fetch_unit_pkg;

  localparam int          OP_WIDTH     = 6;
  localparam int          FUNCT_WIDTH  = 6;
  localparam logic        TRUE         = 1'b1;
  localparam logic        FALSE        = 1'b0;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_WAIT_MAX = 8;
  localparam int          DEF_WAIT_W   = 4;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and instruction registers, req/ack read of
// instruction memory with a bounded wait, and decoded instruction fields.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          WAIT_MAX = DEF_WAIT_MAX,
  parameter int          WAIT_W   = DEF_WAIT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_clk,
  input  logic                   inst_read_en,
  input  logic                   pc_load,
  input  logic [31:0]            pc_next,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            inst,
  output logic [OP_WIDTH-1:0]    op_code,
  output logic [FUNCT_WIDTH-1:0] funct,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [15:0]            imm16,
  output logic [25:0]            addr26,
  output logic                   inst_valid,
  output logic                   fetch_busy,
  output logic                   fetch_fault
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              redir_q, redir_d;
  logic              fault_q, fault_d;
  logic [31:0]       pc_inc;
  logic              start;

  assign pc_inc = pc_q + 32'd4;
  assign start  = if_clk & inst_read_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= INST_NOP;
      valid_q    <= FALSE;
      req_q      <= FALSE;
      addr_q     <= '0;
      wait_cnt_q <= '0;
      redir_q    <= FALSE;
      fault_q    <= FALSE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
      redir_q    <= redir_d;
      fault_q    <= fault_d;
    end
  end

  // redir_q remembers a redirect taken while a fetch is in flight, so the
  // +4 at ack does not clobber the new target.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    redir_d    = redir_q;
    fault_d    = FALSE;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_aligned(pc_q)) begin
            state_d    = S_WAIT;
            req_d      = TRUE;
            addr_d     = pc_q;
            valid_d    = FALSE;
            wait_cnt_d = '0;
            redir_d    = pc_load;
          end else begin
            inst_d  = INST_NOP;
            valid_d = FALSE;
            fault_d = TRUE;
          end
        end
        if (pc_load) pc_d = pc_next;
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          inst_d  = imem_rdata;
          valid_d = TRUE;
          req_d   = FALSE;
          redir_d = FALSE;
          if (pc_load)       pc_d = pc_next;
          else if (!redir_q) pc_d = pc_inc;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          req_d   = FALSE;
          inst_d  = INST_NOP;
          valid_d = FALSE;
          fault_d = TRUE;
          redir_d = FALSE;
          if (pc_load) pc_d = pc_next;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (pc_load) begin
            pc_d    = pc_next;
            redir_d = TRUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    pc          = pc_q;
    pc_plus4    = pc_inc;
    inst        = inst_q;
    op_code     = inst_q[31:26];
    funct       = inst_q[5:0];
    rs          = inst_q[25:21];
    rt          = inst_q[20:16];
    rd          = inst_q[15:11];
    imm16       = inst_q[15:0];
    addr26      = inst_q[25:0];
    inst_valid  = valid_q;
    fetch_busy  = (state_q == S_WAIT);
    fetch_fault = fault_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_fetch_unit;

  localparam int WAIT_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_clk = 1'b0;
  logic        inst_read_en = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc, pc_plus4, inst;
  logic [5:0]  op_code, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        inst_valid, fetch_busy, fetch_fault;

  int checks = 0;
  int passes = 0;

  fetch_unit #(.RESET_PC(32'h0), .WAIT_MAX(WAIT_MAX), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .if_clk(if_clk), .inst_read_en(inst_read_en),
    .pc_load(pc_load), .pc_next(pc_next), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .inst(inst), .op_code(op_code),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .addr26(addr26), .inst_valid(inst_valid), .fetch_busy(fetch_busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  // Reference model: a fetch is "in flight" from its start edge until ack or
  // until WAIT_MAX edges have elapsed since it began.
  logic [31:0] m_pc, m_inst, m_addr;
  logic        m_valid, m_flight, m_fault, m_redirected;
  longint      m_cyc, m_start_cyc;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_addr = 32'h0;
    m_valid = 0; m_flight = 0; m_fault = 0; m_redirected = 0;
  endtask

  task automatic model_step();
    logic [31:0] old_pc;
    old_pc  = m_pc;
    m_fault = 0;
    m_cyc++;
    if (!m_flight) begin
      if (if_clk && inst_read_en) begin
        if (old_pc % 4 != 0) begin
          m_inst = 0; m_valid = 0; m_fault = 1;
        end else begin
          m_flight = 1; m_addr = old_pc; m_valid = 0;
          m_start_cyc = m_cyc; m_redirected = pc_load;
        end
      end
      if (pc_load) m_pc = pc_next;
    end else if (imem_ack) begin
      m_flight = 0; m_inst = imem_rdata; m_valid = 1;
      if (pc_load)            m_pc = pc_next;
      else if (!m_redirected) m_pc = old_pc + 32'd4;
    end else if (m_cyc - m_start_cyc == WAIT_MAX) begin
      m_flight = 0; m_inst = 0; m_valid = 0; m_fault = 1;
      if (pc_load) m_pc = pc_next;
    end else if (pc_load) begin
      m_pc = pc_next; m_redirected = 1;
    end
  endtask

  initial begin
    model_reset();
    m_cyc = 0;
    m_start_cyc = 0;
  end

  always @(negedge rst) model_reset();

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_step();
      #1;
      check_output("m_pc", pc, m_pc);
      check_output("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      check_output("m_inst", inst, m_inst);
      check_output("m_op_code", 32'(op_code), 32'(m_inst[31:26]));
      check_output("m_funct", 32'(funct), 32'(m_inst[5:0]));
      check_output("m_rs", 32'(rs), 32'(m_inst[25:21]));
      check_output("m_rt", 32'(rt), 32'(m_inst[20:16]));
      check_output("m_rd", 32'(rd), 32'(m_inst[15:11]));
      check_output("m_imm16", 32'(imm16), 32'(m_inst[15:0]));
      check_output("m_addr26", 32'(addr26), 32'(m_inst[25:0]));
      check_output("m_inst_valid", 32'(inst_valid), 32'(m_valid));
      check_output("m_imem_req", 32'(imem_req), 32'(m_flight));
      check_output("m_fetch_busy", 32'(fetch_busy), 32'(m_flight));
      check_output("m_fetch_fault", 32'(fetch_fault), 32'(m_fault));
      if (m_flight) check_output("m_imem_addr", imem_addr, m_addr);
    end
  end

  task automatic apply_stimulus(input logic strobe, input logic ack, input logic [31:0] rdata,
                                input logic load, input logic [31:0] target);
    if_clk = strobe; inst_read_en = 1'b1; imem_ack = ack; imem_rdata = rdata;
    pc_load = load; pc_next = target;
    @(negedge clk);
    if_clk = 0; imem_ack = 0; pc_load = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    logic [31:0] keep;

    repeat (3) idle_cycle();
    check_output("reset_pc", pc, 32'h0);
    check_output("reset_inst", inst, 32'h0);
    check_output("reset_req", 32'(imem_req), 0);
    check_output("reset_valid", 32'(inst_valid), 0);
    check_output("reset_busy", 32'(fetch_busy), 0);
    check_output("reset_fault", 32'(fetch_fault), 0);
    rst = 1'b1;
    idle_cycle();

    // First fetch
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("first_req", 32'(imem_req), 1);
    check_output("first_addr", imem_addr, 32'h0);
    apply_stimulus(0, 1, 32'h2008_0005, 0, 0);
    check_output("first_inst", inst, 32'h2008_0005);
    check_output("first_op", 32'(op_code), 32'h08);
    check_output("first_rt", 32'(rt), 8);
    check_output("first_imm", 32'(imm16), 5);
    check_output("first_pc", pc, 32'h4);
    check_output("first_valid", 32'(inst_valid), 1);

    // Slow memory: ack on the fifth waiting cycle, then a stray ack
    apply_stimulus(1, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (fetch_busy) cnt++;
      check_output("slow_addr", imem_addr, 32'h4);
      if (i < 4) idle_cycle();
    end
    apply_stimulus(0, 1, 32'h1234_5678, 0, 0);
    check_output("slow_busy_cycles", cnt, 5);
    check_output("slow_pc", pc, 32'h8);
    check_output("slow_inst", inst, 32'h1234_5678);
    apply_stimulus(0, 1, 32'hDEAD_BEEF, 0, 0);
    check_output("stray_ack_inst", inst, 32'h1234_5678);
    check_output("stray_ack_pc", pc, 32'h8);

    // Timeout
    apply_stimulus(1, 0, 0, 0, 0);
    cnt = 0;
    while (imem_req && cnt < 20) begin
      cnt++;
      idle_cycle();
    end
    check_output("timeout_req_cycles", cnt, WAIT_MAX);
    check_output("timeout_fault", 32'(fetch_fault), 1);
    check_output("timeout_inst", inst, 32'h0);
    check_output("timeout_pc", pc, 32'h8);
    idle_cycle();
    check_output("timeout_fault_pulse", 32'(fetch_fault), 0);

    // Redirect colliding with ack
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 32'h0210_8020, 1, 32'h40);
    check_output("collide_pc", pc, 32'h40);
    check_output("collide_inst", inst, 32'h0210_8020);

    // Redirect during wait suppresses +4
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 32'h100);
    apply_stimulus(0, 1, 32'h0800_0010, 0, 0);
    check_output("redir_wait_pc", pc, 32'h100);
    check_output("redir_wait_addr26", 32'(addr26), 32'h10);

    // Misaligned PC
    apply_stimulus(0, 0, 0, 1, 32'h42);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("misalign_req", 32'(imem_req), 0);
    check_output("misalign_fault", 32'(fetch_fault), 1);
    check_output("misalign_inst", inst, 32'h0);
    check_output("misalign_pc", pc, 32'h42);

    // Wrap, with a strobe ignored while waiting
    apply_stimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("wrap_addr_held", imem_addr, 32'hFFFF_FFFC);
    apply_stimulus(0, 1, 32'h0000_0020, 0, 0);
    check_output("wrap_pc", pc, 32'h0);
    idle_cycle();
    check_output("ignored_strobe_req", 32'(imem_req), 0);

    // Reset asserted mid-wait
    apply_stimulus(1, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_req", 32'(imem_req), 0);
    check_output("async_reset_pc", pc, 32'h0);
    idle_cycle();
    rst = 1'b1;
    idle_cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      if ($urandom_range(0, 9) == 0) keep = r;
      else if ($urandom_range(0, 19) == 0) keep = 32'hFFFF_FFF8 | {r[2], 2'b00};
      else keep = {r[31:2], 2'b00};
      if_clk       = ($urandom_range(0, 9) < 3);
      inst_read_en = ($urandom_range(0, 9) < 8);
      imem_ack     = ($urandom_range(0, 9) < 2);
      imem_rdata   = $urandom;
      pc_load      = ($urandom_range(0, 19) == 0);
      pc_next      = keep;
      @(negedge clk);
    end
    if_clk = 0; imem_ack = 0; pc_load = 0;
    repeat (2) idle_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
